// File: rtl/mini16_io_regs_if.sv
// CPU-side register bus for mini16_io_regs: a write port (we/w_addr/w_data)
// and a read port (r_addr in, registered r_data out).
interface mini16_io_regs_if #(
  parameter int WIDTH_D      = 16,
  parameter int DEPTH_IO_REG = 5
);
  logic                    we;
  logic [DEPTH_IO_REG-1:0] w_addr;
  logic [WIDTH_D-1:0]      w_data;
  logic [DEPTH_IO_REG-1:0] r_addr;
  logic [WIDTH_D-1:0]      r_data;

  modport master (
    output we, w_addr, w_data, r_addr,
    input  r_data
  );

  modport slave (
    input  we, w_addr, w_data, r_addr,
    output r_data
  );
endinterface

// File: rtl/mini16_io_regs.sv
// mini16_io_regs: memory-mapped I/O register block for mini16 SoCs.
// GPIO output registers with readback, a TX byte FIFO drained into uart_io
// by a handshake FSM, and status/level registers for the CPU.
// Optional IRQ output and mask register: define MINI16_IO_IRQ_EN.
module mini16_io_regs #(
  parameter int WIDTH_D       = 16,
  parameter int DEPTH_IO_REG  = 5,
  parameter int NUM_GPIO_OUT  = 2,
  parameter int DEPTH_TX_FIFO = 3,
  parameter int BUSY_TIMEOUT  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  mini16_io_regs_if.slave                 bus,
  output logic [NUM_GPIO_OUT*WIDTH_D-1:0] gpio_out,
  output logic [7:0]                      tx_data,
  output logic                            tx_we,
  input  logic                            tx_busy
`ifdef MINI16_IO_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam int FIFO_ENTRIES = 1 << DEPTH_TX_FIFO;
  localparam int TO_W         = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [DEPTH_IO_REG-1:0] ADDR_STATUS  = DEPTH_IO_REG'(0);
  localparam logic [DEPTH_IO_REG-1:0] ADDR_LEVEL   = DEPTH_IO_REG'(1);
  localparam logic [DEPTH_IO_REG-1:0] ADDR_TX_PUSH = DEPTH_IO_REG'(16);
  localparam logic [DEPTH_IO_REG-1:0] ADDR_TX_CLR  = DEPTH_IO_REG'(17);
`ifdef MINI16_IO_IRQ_EN
  localparam logic [DEPTH_IO_REG-1:0] ADDR_IRQ_MASK = DEPTH_IO_REG'(18);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  // Stage-1 write registers
  logic                    we_q;
  logic [DEPTH_IO_REG-1:0] w_addr_q;
  logic [WIDTH_D-1:0]      w_data_q;

  // GPIO registers
  logic [NUM_GPIO_OUT-1:0][WIDTH_D-1:0] gpio_q, gpio_d;

  // TX FIFO
  logic [7:0]             fifo_mem [FIFO_ENTRIES];
  logic [DEPTH_TX_FIFO:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_TX_FIFO:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_TX_FIFO:0] fifo_level;
  logic                   overflow_q, overflow_d;
  logic                   fifo_empty, fifo_full;
  logic                   push_req, clear_req, push_ok, pop;
  logic [7:0]             fifo_head;

  // Drain FSM
  state_t          state_q, state_d;
  logic            tx_we_q, tx_we_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Read port
  logic [WIDTH_D-1:0] r_data_d, r_data_q;
  logic               status_busy;

`ifdef MINI16_IO_IRQ_EN
  logic [1:0] mask_q, mask_d;
  logic       tx_done_empty_q, tx_done_empty_d;
  logic       irq_q, irq_d;
`endif

  // Decode of the stage-1 write and FIFO flags; a pop only happens from IDLE
  // and a clear beats both push and pop on the same edge.
  always_comb begin
    push_req   = we_q && (w_addr_q == ADDR_TX_PUSH);
    clear_req  = we_q && (w_addr_q == ADDR_TX_CLR);
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[DEPTH_TX_FIFO] != rd_ptr_q[DEPTH_TX_FIFO]) &&
                 (wr_ptr_q[DEPTH_TX_FIFO-1:0] == rd_ptr_q[DEPTH_TX_FIFO-1:0]);
    fifo_level = wr_ptr_q - rd_ptr_q;
    fifo_head  = fifo_mem[rd_ptr_q[DEPTH_TX_FIFO-1:0]];
    pop        = (state_q == ST_IDLE) && !fifo_empty && !tx_busy && !clear_req;
    push_ok    = push_req && !clear_req && (!fifo_full || pop);
  end

  // Next FIFO pointers and sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (clear_req) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok)
        wr_ptr_d = wr_ptr_q + 1'b1;
      if (push_req && !push_ok)
        overflow_d = 1'b1;
      if (pop)
        rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Drain FSM next state: issue one strobe per byte, wait for uart_io to
  // go busy (or give up after BUSY_TIMEOUT cycles), then wait for it to finish.
  always_comb begin
    state_d   = state_q;
    tx_we_d   = 1'b0;
    tx_data_d = tx_data_q;
    to_cnt_d  = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_data_d = fifo_head;
          tx_we_d   = 1'b1;
          to_cnt_d  = '0;
          state_d   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy)
          state_d = ST_WAIT_DONE;
        else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1))
          state_d = ST_IDLE;
        else
          to_cnt_d = to_cnt_q + TO_W'(1);
      end
      ST_WAIT_DONE: begin
        if (!tx_busy)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // GPIO writes from the stage-1 registers.
  always_comb begin
    gpio_d = gpio_q;
    for (int g = 0; g < NUM_GPIO_OUT; g++) begin
      if (we_q && (w_addr_q == DEPTH_IO_REG'(g + 1)))
        gpio_d[g] = w_data_q;
    end
  end

  // Read mux; unmapped addresses return zero.
  always_comb begin
    status_busy = tx_busy || !fifo_empty || (state_q != ST_IDLE);
    r_data_d    = '0;
    if (bus.r_addr == ADDR_STATUS) begin
      r_data_d[0] = status_busy;
      r_data_d[1] = fifo_full;
      r_data_d[2] = overflow_q;
    end else if (bus.r_addr == ADDR_LEVEL) begin
      r_data_d = WIDTH_D'(fifo_level);
    end
    for (int g = 0; g < NUM_GPIO_OUT; g++) begin
      if (bus.r_addr == DEPTH_IO_REG'(g + 2))
        r_data_d = gpio_q[g];
    end
`ifdef MINI16_IO_IRQ_EN
    if (bus.r_addr == ADDR_IRQ_MASK)
      r_data_d = WIDTH_D'(mask_q);
`endif
  end

`ifdef MINI16_IO_IRQ_EN
  // IRQ mask, sticky TX-done-empty flag and the registered interrupt line.
  always_comb begin
    mask_d = mask_q;
    if (we_q && (w_addr_q == ADDR_IRQ_MASK))
      mask_d = w_data_q[1:0];
    tx_done_empty_d = tx_done_empty_q;
    if ((state_q != ST_IDLE) && (state_d == ST_IDLE) && (wr_ptr_d == rd_ptr_d))
      tx_done_empty_d = 1'b1;
    if (push_req || clear_req)
      tx_done_empty_d = 1'b0;
    irq_d = (mask_d[0] && tx_done_empty_d) || (mask_d[1] && overflow_d);
  end

  // IRQ state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q          <= '0;
      tx_done_empty_q <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      mask_q          <= mask_d;
      tx_done_empty_q <= tx_done_empty_d;
      irq_q           <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  // Stage-1 write pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      we_q     <= bus.we;
      w_addr_q <= bus.w_addr;
      w_data_q <= bus.w_data;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr_q[DEPTH_TX_FIFO-1:0]] <= w_data_q[7:0];
  end

  // FIFO pointers, overflow, GPIO and read data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      gpio_q     <= '0;
      r_data_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      gpio_q     <= gpio_d;
      r_data_q   <= r_data_d;
    end
  end

  // Drain FSM state with its registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tx_we_q   <= 1'b0;
      tx_data_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      tx_we_q   <= tx_we_d;
      tx_data_q <= tx_data_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign gpio_out   = gpio_q;
  assign tx_data    = tx_data_q;
  assign tx_we      = tx_we_q;
  assign bus.r_data = r_data_q;

endmodule

// File: tb/tb_mini16_io_regs.sv
// Self-checking bench for mini16_io_regs: GPIO write/readback, TX FIFO
// draining against a uart_io busy model, overflow/clear, busy timeout,
// asynchronous reset and, when MINI16_IO_IRQ_EN is defined, the IRQ line.
module tb_mini16_io_regs;

  localparam int WIDTH_D      = 16;
  localparam int DEPTH_IO_REG = 5;
  localparam int NUM_GPIO_OUT = 2;
  localparam int BUSY_TIMEOUT = 4;

  logic                            clk;
  logic                            reset;
  logic [NUM_GPIO_OUT*WIDTH_D-1:0] gpio_out;
  logic [7:0]                      tx_data;
  logic                            tx_we;
  logic                            tx_busy;
`ifdef MINI16_IO_IRQ_EN
  logic                            irq;
`endif

  mini16_io_regs_if #(.WIDTH_D(WIDTH_D), .DEPTH_IO_REG(DEPTH_IO_REG)) bus ();

  mini16_io_regs #(
    .WIDTH_D      (WIDTH_D),
    .DEPTH_IO_REG (DEPTH_IO_REG),
    .NUM_GPIO_OUT (NUM_GPIO_OUT),
    .DEPTH_TX_FIFO(3),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .gpio_out(gpio_out),
    .tx_data (tx_data),
    .tx_we   (tx_we),
    .tx_busy (tx_busy)
`ifdef MINI16_IO_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCount  = 0;
  int pulseCount  = 0;
  int busyMode    = 0;
  int delayCnt    = 0;
  int holdCnt     = 0;
  logic       prevWe = 1'b0;
  logic [7:0] txExpected [$];
  int         pulseTimes [$];

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time the strobes.
  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One-cycle bus write; it returns at the falling edge after the stage-1 edge.
  task automatic applyStimulus(input logic [4:0] addr, input logic [15:0] data);
    bus.we     = 1'b1;
    bus.w_addr = addr;
    bus.w_data = data;
    @(negedge clk);
    bus.we     = 1'b0;
  endtask

  task automatic readReg(input logic [4:0] addr, output logic [15:0] value);
    bus.r_addr = addr;
    @(negedge clk);
    value = bus.r_data;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Wait until every expected byte has been sent and the busy model is idle.
  task automatic waitDrain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (txExpected.size() == 0 && delayCnt == 0 && holdCnt == 0 && !tx_busy) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput(tag, 32'(done), 1);
    waitCycles(6);
  endtask

  // uart_io busy model: mode 0 rises 2 cycles after a strobe and holds for
  // 10 cycles; mode 1 holds busy high; mode 2 never asserts busy.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busyMode == 1) begin
        tx_busy = 1'b1;
      end else if (busyMode == 2) begin
        tx_busy = 1'b0;
      end else begin
        if (delayCnt > 0) begin
          delayCnt--;
          if (delayCnt == 0) begin
            tx_busy = 1'b1;
            holdCnt = 10;
          end
        end else if (holdCnt > 0) begin
          holdCnt--;
          if (holdCnt == 0) tx_busy = 1'b0;
        end else begin
          tx_busy = 1'b0;
        end
        if (tx_we && !reset) delayCnt = 2;
      end
    end
  end

  // Scoreboard monitor: every strobe pops one expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_we) begin
        pulseCount++;
        pulseTimes.push_back(cycleCount);
        checkOutput("tx_we_one_cycle", 32'(prevWe), 0);
        if (txExpected.size() == 0) begin
          checkOutput("tx_expected_pending", 32'(txExpected.size()), 1);
        end else begin
          checkOutput("tx_data", 32'(tx_data), 32'(txExpected.pop_front()));
        end
      end
      prevWe = tx_we;
    end
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, testsFailed=%0d", testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [15:0] rd;
    bit          allBusy;
    bit          seen;
    int          base;

    reset      = 1'b1;
    bus.we     = 1'b0;
    bus.w_addr = '0;
    bus.w_data = '0;
    bus.r_addr = '0;
    waitCycles(3);
    reset = 1'b0;

    // Reset values
    checkOutput("rst_gpio", gpio_out, 0);
    checkOutput("rst_tx_we", 32'(tx_we), 0);
    checkOutput("rst_tx_data", 32'(tx_data), 0);
    checkOutput("rst_r_data", 32'(bus.r_data), 0);
    readReg(5'd0, rd);
    checkOutput("rst_status", 32'(rd), 0);

    // GPIO writes take effect two edges after the write cycle
    applyStimulus(5'd1, 16'hA5A5);
    checkOutput("gpio0_not_yet", gpio_out, 0);
    @(negedge clk);
    checkOutput("gpio0_written", gpio_out, 32'h0000_A5A5);
    applyStimulus(5'd2, 16'h1234);
    @(negedge clk);
    checkOutput("gpio_both", gpio_out, 32'h1234_A5A5);
    applyStimulus(5'd3, 16'hFFFF);
    @(negedge clk);
    checkOutput("gpio_unmapped_write", gpio_out, 32'h1234_A5A5);
    readReg(5'd2, rd);
    checkOutput("read_gpio0", 32'(rd), 32'hA5A5);
    readReg(5'd3, rd);
    checkOutput("read_gpio1", 32'(rd), 32'h1234);
    readReg(5'd10, rd);
    checkOutput("read_unmapped", 32'(rd), 0);
    applyStimulus(5'd18, 16'h0003);
    @(negedge clk);
`ifdef MINI16_IO_IRQ_EN
    readReg(5'd18, rd);
    checkOutput("read_mask", 32'(rd), 3);
    applyStimulus(5'd18, 16'h0000);
    @(negedge clk);
`else
    readReg(5'd18, rd);
    checkOutput("read_addr18_disabled", 32'(rd), 0);
`endif

    // Two bytes through the busy model; status stays busy throughout
    base = pulseCount;
    bus.r_addr = 5'd0;
    txExpected.push_back(8'h48);
    applyStimulus(5'd16, 16'h0048);
    txExpected.push_back(8'h69);
    applyStimulus(5'd16, 16'h0069);
    waitCycles(2);
    allBusy = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pulseCount - base >= 2 && delayCnt == 0 && holdCnt == 0 && !tx_busy) begin
        seen = 1'b1;
        break;
      end
      if (!bus.r_data[0]) allBusy = 1'b0;
    end
    checkOutput("hi_finished", 32'(seen), 1);
    checkOutput("hi_status_busy_held", 32'(allBusy), 1);
    waitCycles(3);
    checkOutput("hi_status_idle", 32'(bus.r_data), 0);
    checkOutput("hi_pulse_count", 32'(pulseCount - base), 2);

    // Overflow with uart_io held busy, then clear
    busyMode = 1;
    waitCycles(2);
    for (int i = 0; i < 9; i++) applyStimulus(5'd16, 16'(8'hC0 + i));
    @(negedge clk);
    readReg(5'd1, rd);
    checkOutput("ovf_level", 32'(rd), 8);
    readReg(5'd0, rd);
    checkOutput("ovf_status", 32'(rd), 32'h7);
    applyStimulus(5'd17, 16'h0000);
    @(negedge clk);
    readReg(5'd1, rd);
    checkOutput("clr_level", 32'(rd), 0);
    busyMode = 0;
    waitCycles(3);
    readReg(5'd0, rd);
    checkOutput("clr_status", 32'(rd), 0);

    // uart_io never goes busy: timeout, then the next byte follows
    busyMode = 2;
    pulseTimes.delete();
    txExpected.push_back(8'h11);
    applyStimulus(5'd16, 16'h0011);
    txExpected.push_back(8'h22);
    applyStimulus(5'd16, 16'h0022);
    waitDrain("timeout_drain");
    checkOutput("timeout_pulses", 32'(pulseTimes.size()), 2);
    if (pulseTimes.size() == 2)
      checkOutput("timeout_gap", 32'(pulseTimes[1] - pulseTimes[0]), BUSY_TIMEOUT + 1);
    busyMode = 0;
    waitCycles(2);

`ifdef MINI16_IO_IRQ_EN
    // TX-empty interrupt
    checkOutput("irq_masked", 32'(irq), 0);
    applyStimulus(5'd18, 16'h0001);
    txExpected.push_back(8'h4B);
    applyStimulus(5'd16, 16'h004B);
    waitDrain("irq_drain1");
    checkOutput("irq_set", 32'(irq), 1);
    txExpected.push_back(8'h4F);
    applyStimulus(5'd16, 16'h004F);
    @(negedge clk);
    checkOutput("irq_cleared_by_push", 32'(irq), 0);
    waitDrain("irq_drain2");
    checkOutput("irq_set_again", 32'(irq), 1);
`endif

    // Reset asserted while a strobe is on the wire
    bus.r_addr = 5'd2;
    applyStimulus(5'd16, 16'h0055);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (tx_we) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("rst_mid_strobe_seen", 32'(seen), 1);
    checkOutput("rst_mid_pre_data", 32'(tx_data), 32'h55);
    checkOutput("rst_mid_pre_rdata", 32'(bus.r_data), 32'hA5A5);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_tx_we", 32'(tx_we), 0);
    checkOutput("rst_mid_tx_data", 32'(tx_data), 0);
    checkOutput("rst_mid_gpio", gpio_out, 0);
    checkOutput("rst_mid_r_data", 32'(bus.r_data), 0);
`ifdef MINI16_IO_IRQ_EN
    checkOutput("rst_mid_irq", 32'(irq), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    readReg(5'd0, rd);
    checkOutput("rst_mid_status", 32'(rd), 0);
    readReg(5'd1, rd);
    checkOutput("rst_mid_level", 32'(rd), 0);
    waitCycles(20);
    checkOutput("scoreboard_empty", 32'(txExpected.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
